can_reg_bus_if: RTL

CAN_REG_BUS_IF -- requirements
Module: can_reg_bus_if

---
 rtl/can_pkg.sv | 22 ++
 rtl/can_reg_bus_if_if.sv | 37 +++
 rtl/can_sync_bit.sv | 25 ++
 rtl/can_reg_bus_if.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared definitions for the CAN controller host register bus interface:
// FSM state encoding and the default register address/data widths.
package can_pkg;

  // Default register-file geometry used by the bus interface and its interface bundle
  localparam int CAN_ADDR_WIDTH = 8;
  localparam int CAN_DATA_WIDTH = 8;

  // Legal range of synchronizer depth for the asynchronous host strobes
  localparam int CAN_SYNC_MIN = 2;
  localparam int CAN_SYNC_MAX = 4;

  // Host access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RDATA   = 3'd3,
    ST_RELEASE = 3'd4
  } can_state_e;

endpackage

// File: rtl/can_reg_bus_if_if.sv
// Host-side asynchronous register bus bundle. The master modport is the
// external host (or a bench standing in for it); the slave modport is the
// bus interface block that synchronizes the strobes and answers reads.
interface can_reg_bus_if_if #(
  parameter int ADDR_WIDTH = can_pkg::CAN_ADDR_WIDTH,
  parameter int DATA_WIDTH = can_pkg::CAN_DATA_WIDTH
) ();

  logic                  bus_cs_n;
  logic                  bus_wr_n;
  logic                  bus_rd_n;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_rdata_oe;

  modport master (
    output bus_cs_n,
    output bus_wr_n,
    output bus_rd_n,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_rdata_oe
  );

  modport slave (
    input  bus_cs_n,
    input  bus_wr_n,
    input  bus_rd_n,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_rdata_oe
  );

endinterface

// File: rtl/can_sync_bit.sv
// Single-bit multi-stage synchronizer for an asynchronous active-low strobe.
// Every stage resets to 1 so a strobe reads as inactive out of reset.
module can_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw input through the flip-flop chain toward the output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/can_reg_bus_if.sv
// Asynchronous host register bus to synchronous register-file bridge.
// Strobes are synchronized, each host access produces exactly one reg_we or
// reg_re pulse, and a new access is only accepted once both strobes have been
// observed inactive again. Simultaneous write and read strobes are flagged as
// a sticky protocol error and produce no register access.
module can_reg_bus_if
  import can_pkg::*;
#(
  parameter int ADDR_WIDTH  = CAN_ADDR_WIDTH,
  parameter int DATA_WIDTH  = CAN_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int U_DLY       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  can_reg_bus_if_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  proto_err,
  input  logic                  proto_err_clr
);

  // Reject synchronizer depths outside the supported range at elaboration
  if (SYNC_STAGES < CAN_SYNC_MIN || SYNC_STAGES > CAN_SYNC_MAX || U_DLY < 0) begin : g_param_check
    $error("can_reg_bus_if: SYNC_STAGES must be 2..4 and U_DLY non-negative");
  end

  // Synchronized strobes (active-low) and derived requests
  logic cs_s;
  logic wr_s;
  logic rd_s;
  logic wr_req;
  logic rd_req;

  // Post-reset qualification: the synchronizers must have flushed their reset
  // value and shown both requests inactive before any access is accepted
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   flushed;
  logic                   armed_q;
  logic                   armed_d;

  // Sequencer state
  can_state_e state_q;
  can_state_e state_d;

  // Registered outputs
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [ADDR_WIDTH-1:0] reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q;
  logic [DATA_WIDTH-1:0] reg_wdata_d;
  logic                  reg_we_q;
  logic                  reg_we_d;
  logic                  reg_re_q;
  logic                  reg_re_d;
  logic [DATA_WIDTH-1:0] bus_rdata_q;
  logic [DATA_WIDTH-1:0] bus_rdata_d;
  logic                  rdata_oe_q;
  logic                  rdata_oe_d;
  logic                  proto_err_q;
  logic                  proto_err_d;

  can_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d_i (bus.bus_cs_n),
    .q_o (cs_s)
  );

  can_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk (clk),
    .rst (rst),
    .d_i (bus.bus_wr_n),
    .q_o (wr_s)
  );

  can_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk (clk),
    .rst (rst),
    .d_i (bus.bus_rd_n),
    .q_o (rd_s)
  );

  assign wr_req  = !cs_s && !wr_s;
  assign rd_req  = !cs_s && !rd_s;
  assign flushed = flush_q[SYNC_STAGES-1];
  assign armed_d = armed_q || (flushed && !wr_req && !rd_req);

  // Track synchronizer flush after reset and arm once the bus is seen idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      bus_rdata_q <= '0;
      rdata_oe_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      bus_rdata_q <= bus_rdata_d;
      rdata_oe_q  <= rdata_oe_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state decode: one access per strobe assertion, then wait for release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q) begin
          if (wr_req && rd_req) begin
            state_d = ST_RELEASE;
          end else if (wr_req) begin
            state_d = ST_WRITE;
          end else if (rd_req) begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE:   state_d = ST_RELEASE;
      ST_READ:    state_d = ST_RDATA;
      ST_RDATA:   state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!wr_req && !rd_req) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output next values: capture on access start, pulse strobes, manage read data
  always_comb begin
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    bus_rdata_d = bus_rdata_q;
    rdata_oe_d  = rdata_oe_q;
    proto_err_d = proto_err_q;

    if (proto_err_clr) begin
      proto_err_d = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      if (state_d == ST_WRITE) begin
        reg_we_d    = 1'b1;
        reg_addr_d  = bus.bus_addr;
        reg_wdata_d = bus.bus_wdata;
      end
      if (state_d == ST_READ) begin
        reg_re_d   = 1'b1;
        reg_addr_d = bus.bus_addr;
      end
      if (state_d == ST_RELEASE) begin
        proto_err_d = 1'b1;
      end
    end

    if (state_q == ST_RDATA) begin
      bus_rdata_d = reg_rdata;
      rdata_oe_d  = 1'b1;
    end

    if (state_q == ST_RELEASE && state_d == ST_IDLE) begin
      rdata_oe_d = 1'b0;
    end
  end

  assign reg_addr         = reg_addr_q;
  assign reg_wdata        = reg_wdata_q;
  assign reg_we           = reg_we_q;
  assign reg_re           = reg_re_q;
  assign proto_err        = proto_err_q;
  assign bus.bus_rdata    = bus_rdata_q;
  assign bus.bus_rdata_oe = rdata_oe_q;

endmodule
